// File: rtl/rgb_pkg.sv
// Shared types for the RGB pixel link transmit side.
// Contents:
//   PIXEL_BYTES  - number of bytes each pixel is sent as on the byte stream
//   rgb_t        - one 24-bit pixel, with the fields packed as b,g,r
//   rgb_entry_t  - one pixel FIFO entry: the end-of-line flag plus the pixel
//   ser_state_t  - serializer FSM states
//   wire_byte    - picks the byte sent in a given byte slot of a pixel
package rgb_pkg;

  localparam int PIXEL_BYTES = 3;

  typedef struct packed {
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } rgb_t;

  typedef struct packed {
    logic last;
    rgb_t px;
  } rgb_entry_t;

  typedef logic [$clog2(PIXEL_BYTES)-1:0] byte_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    B0,
    B1,
    B2
  } ser_state_t;

  // Slot 0 carries red (blue when bgr is set), slot 1 always carries green and
  // slot 2 carries the remaining colour.
  function automatic logic [7:0] wire_byte(rgb_t px, byte_idx_t idx, logic bgr);
    logic [7:0] sel;
    case (idx)
      2'd0:    sel = bgr ? px.b : px.r;
      2'd1:    sel = px.g;
      default: sel = bgr ? px.r : px.b;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock register FIFO with occupancy count.
// Ports:
//   clk    in            clock, all logic on posedge
//   reset  in            asynchronous active-high reset, empties the FIFO
//   push   in            write wdata (ignored when full)
//   wdata  in  WIDTH     data to write
//   pop    in            drop the head entry (ignored when empty)
//   rdata  out WIDTH     head entry, valid while not empty
//   full   out           level == DEPTH
//   empty  out           level == 0
//   level  out AW+1      occupied entries
module sync_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally. A simultaneous
  // push and pop leaves the level where it was.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/rgb_byte_serializer.sv
// Transmit side of the RGB pixel link: buffers whole pixels and sends each
// one as three bytes on a byte-wide valid/ready stream.
// Ports:
//   clk          in       clock
//   reset        in       asynchronous active-high reset
//   pix_valid    in       pixel offered
//   pix_ready    out      pixel taken when pix_valid & pix_ready
//   pix_r/g/b    in  8    colour fields
//   pix_last     in       pixel ends its line
//   byte_valid   out      byte_data valid
//   byte_ready   in       sink takes the byte when byte_valid & byte_ready
//   byte_data    out 8    serialized byte
//   byte_first   out      first byte of a pixel
//   byte_last    out      third byte of a pixel flagged pix_last
//   fifo_level   out      occupied pixel FIFO entries
//   pixel_count  out 16   pixels completely sent since reset (wraps)
module rgb_byte_serializer
  import rgb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter bit BGR_ORDER  = 1'b0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pix_valid,
  output logic                        pix_ready,
  input  logic [7:0]                  pix_r,
  input  logic [7:0]                  pix_g,
  input  logic [7:0]                  pix_b,
  input  logic                        pix_last,
  output logic                        byte_valid,
  input  logic                        byte_ready,
  output logic [7:0]                  byte_data,
  output logic                        byte_first,
  output logic                        byte_last,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [15:0]                 pixel_count
);

  ser_state_t state_q;
  ser_state_t state_d;
  rgb_entry_t push_entry;
  rgb_entry_t head_entry;
  rgb_entry_t hold_q;
  logic       ready_en_q;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_push;
  logic       fifo_pop;
  logic       out_fire;
  logic [15:0] pixel_count_q;

  // pix_ready comes purely from registers; ready_en_q keeps it low while
  // reset is held, since an empty FIFO would otherwise report ready.
  assign pix_ready   = ready_en_q & ~fifo_full;
  assign fifo_push   = pix_valid & pix_ready;
  assign byte_valid  = (state_q != IDLE);
  assign out_fire    = byte_valid & byte_ready;
  assign pixel_count = pixel_count_q;

  always_comb begin
    push_entry.last = pix_last;
    push_entry.px.r = pix_r;
    push_entry.px.g = pix_g;
    push_entry.px.b = pix_b;
  end

  sync_fifo #(
    .WIDTH ($bits(rgb_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (push_entry),
    .pop   (fifo_pop),
    .rdata (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ready_en_q <= 1'b0;
    else       ready_en_q <= 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next pixel is popped either from IDLE or on the last byte's handshake,
  // so back-to-back pixels leave no idle cycle on the byte stream.
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = B0;
        end
      end
      B0: if (out_fire) state_d = B1;
      B1: if (out_fire) state_d = B2;
      B2: begin
        if (out_fire) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = B0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The holding register is the pixel on the wire; it only changes on a pop,
  // which keeps the byte outputs stable while the sink stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         hold_q <= '0;
    else if (fifo_pop) hold_q <= head_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            pixel_count_q <= '0;
    else if ((state_q == B2) && out_fire) pixel_count_q <= pixel_count_q + 16'd1;
  end

  always_comb begin
    byte_data = 8'h00;
    unique case (state_q)
      B0:      byte_data = wire_byte(hold_q.px, 2'd0, BGR_ORDER);
      B1:      byte_data = wire_byte(hold_q.px, 2'd1, BGR_ORDER);
      B2:      byte_data = wire_byte(hold_q.px, 2'd2, BGR_ORDER);
      default: byte_data = 8'h00;
    endcase
  end

  assign byte_first = (state_q == B0);
  assign byte_last  = (state_q == B2) && hold_q.last;

endmodule

// File: tb/tb_rgb_byte_serializer.sv
// Bench for rgb_byte_serializer: two instances (r,g,b and b,g,r byte order)
// share one stimulus stream; each has its own expected-byte queue.
module tb_rgb_byte_serializer;

  typedef struct packed {
    logic [7:0] data;
    logic       first;
    logic       last;
    logic       third;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pix_valid = 1'b0;
  logic [7:0] pix_r = 8'h00;
  logic [7:0] pix_g = 8'h00;
  logic [7:0] pix_b = 8'h00;
  logic       pix_last = 1'b0;
  logic       byte_ready = 1'b0;

  logic        pix_ready_a, byte_valid_a, byte_first_a, byte_last_a;
  logic [7:0]  byte_data_a;
  logic [2:0]  fifo_level_a;
  logic [15:0] pixel_count_a;
  logic        pix_ready_b, byte_valid_b, byte_first_b, byte_last_b;
  logic [7:0]  byte_data_b;
  logic [2:0]  fifo_level_b;
  logic [15:0] pixel_count_b;

  exp_t        q_rgb[$];
  exp_t        q_bgr[$];
  logic [15:0] cnt_rgb = 16'd0;
  logic [15:0] cnt_bgr = 16'd0;
  logic        pix_hs = 1'b0;
  logic        hs_rgb = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  rgb_byte_serializer #(.FIFO_DEPTH(4), .BGR_ORDER(1'b0)) u_dut_rgb (
    .clk(clk), .reset(reset),
    .pix_valid(pix_valid), .pix_ready(pix_ready_a),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .pix_last(pix_last),
    .byte_valid(byte_valid_a), .byte_ready(byte_ready), .byte_data(byte_data_a),
    .byte_first(byte_first_a), .byte_last(byte_last_a),
    .fifo_level(fifo_level_a), .pixel_count(pixel_count_a)
  );

  rgb_byte_serializer #(.FIFO_DEPTH(4), .BGR_ORDER(1'b1)) u_dut_bgr (
    .clk(clk), .reset(reset),
    .pix_valid(pix_valid), .pix_ready(pix_ready_b),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .pix_last(pix_last),
    .byte_valid(byte_valid_b), .byte_ready(byte_ready), .byte_data(byte_data_b),
    .byte_first(byte_first_b), .byte_last(byte_last_b),
    .fifo_level(fifo_level_b), .pixel_count(pixel_count_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs, scores both byte streams against their
  // queues, records accepted pixels, then advances to the next falling edge.
  task automatic applyStimulus(input logic v, input logic [7:0] r, input logic [7:0] g,
                               input logic [7:0] b, input logic l, input logic br);
    exp_t e;
    pix_valid = v; pix_r = r; pix_g = g; pix_b = b; pix_last = l; byte_ready = br;
    #1;
    checkOutput("count_rgb", 32'(pixel_count_a), 32'(cnt_rgb));
    checkOutput("count_bgr", 32'(pixel_count_b), 32'(cnt_bgr));
    hs_rgb = 1'b0;
    if (byte_valid_a) begin
      if (q_rgb.size() == 0) checkOutput("spurious_rgb", 32'(byte_valid_a), 32'd0);
      else begin
        e = q_rgb[0];
        checkOutput("byte_rgb", 32'({byte_data_a, byte_first_a, byte_last_a}),
                    32'({e.data, e.first, e.last}));
        if (br) begin
          void'(q_rgb.pop_front());
          hs_rgb = 1'b1;
          if (e.third) cnt_rgb = cnt_rgb + 16'd1;
        end
      end
    end
    if (byte_valid_b) begin
      if (q_bgr.size() == 0) checkOutput("spurious_bgr", 32'(byte_valid_b), 32'd0);
      else begin
        e = q_bgr[0];
        checkOutput("byte_bgr", 32'({byte_data_b, byte_first_b, byte_last_b}),
                    32'({e.data, e.first, e.last}));
        if (br) begin
          void'(q_bgr.pop_front());
          if (e.third) cnt_bgr = cnt_bgr + 16'd1;
        end
      end
    end
    pix_hs = v && pix_ready_a;
    if (pix_hs) begin
      q_rgb.push_back(exp_t'{data: r, first: 1'b1, last: 1'b0, third: 1'b0});
      q_rgb.push_back(exp_t'{data: g, first: 1'b0, last: 1'b0, third: 1'b0});
      q_rgb.push_back(exp_t'{data: b, first: 1'b0, last: l,    third: 1'b1});
    end
    if (v && pix_ready_b) begin
      q_bgr.push_back(exp_t'{data: b, first: 1'b1, last: 1'b0, third: 1'b0});
      q_bgr.push_back(exp_t'{data: g, first: 1'b0, last: 1'b0, third: 1'b0});
      q_bgr.push_back(exp_t'{data: r, first: 1'b0, last: l,    third: 1'b1});
    end
    @(negedge clk);
  endtask

  task automatic sendPixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                           input logic l, input bit rnd_ready);
    int budget = 200;
    pix_hs = 1'b0;
    while (!pix_hs && budget > 0) begin
      applyStimulus(1'b1, r, g, b, l, rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1);
      budget--;
    end
    if (!pix_hs) checkOutput("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int budget = 300;
    while ((q_rgb.size() != 0 || q_bgr.size() != 0 || byte_valid_a || byte_valid_b) && budget > 0) begin
      applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
      budget--;
    end
    checkOutput("drain_left", 32'(q_rgb.size() + q_bgr.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n_bytes;
    int first_cyc;
    int last_cyc;
    int idx;
    int budget;
    logic saw_full;

    // Reset state, while reset is still held.
    #2;
    checkOutput("rst_ready",   32'(pix_ready_a),   32'd0);
    checkOutput("rst_valid",   32'(byte_valid_a),  32'd0);
    checkOutput("rst_data",    32'(byte_data_a),   32'd0);
    checkOutput("rst_first",   32'(byte_first_a),  32'd0);
    checkOutput("rst_last",    32'(byte_last_a),   32'd0);
    checkOutput("rst_level",   32'(fifo_level_a),  32'd0);
    checkOutput("rst_count",   32'(pixel_count_a), 32'd0);
    checkOutput("rst_valid_b", 32'(byte_valid_b),  32'd0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_ready_held", 32'(pix_ready_a), 32'd0);
    reset = 1'b0;
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    checkOutput("ready_after_rst", 32'(pix_ready_a), 32'd1);

    $display("[TB] single pixel 11/22/33 with last");
    applyStimulus(1'b1, 8'h11, 8'h22, 8'h33, 1'b1, 1'b1);
    checkOutput("t1_accept", 32'(pix_hs), 32'd1);
    checkOutput("t1_not_yet", 32'(byte_valid_a), 32'd0);
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    checkOutput("t1_first_byte", 32'({byte_valid_a, byte_first_a, byte_data_a}), 32'({1'b1, 1'b1, 8'h11}));
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    checkOutput("t1_second_byte", 32'({byte_valid_a, byte_first_a, byte_data_a}), 32'({1'b1, 1'b0, 8'h22}));
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    checkOutput("t1_third_byte", 32'({byte_valid_a, byte_last_a, byte_data_a}), 32'({1'b1, 1'b1, 8'h33}));
    drain();
    checkOutput("t1_count", 32'(pixel_count_a), 32'd1);

    $display("[TB] byte order check with AA/BB/CC");
    applyStimulus(1'b1, 8'hAA, 8'hBB, 8'hCC, 1'b0, 1'b1);
    checkOutput("t4_accept", 32'(pix_hs), 32'd1);
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    checkOutput("t4_bgr_b0", 32'(byte_data_b), 32'hCC);
    checkOutput("t4_rgb_b0", 32'(byte_data_a), 32'hAA);
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    checkOutput("t4_bgr_b1", 32'(byte_data_b), 32'hBB);
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    checkOutput("t4_bgr_b2", 32'({byte_data_b, byte_last_b}), 32'({8'hAA, 1'b0}));
    drain();

    $display("[TB] eight pixels back to back");
    n_bytes = 0; first_cyc = -1; last_cyc = -1; idx = 0; saw_full = 1'b0;
    budget = 0;
    while (n_bytes < 24 && budget < 200) begin
      if (idx < 8)
        applyStimulus(1'b1, 8'(8'h20 + idx), 8'(8'h40 + idx), 8'(8'h60 + idx), idx == 7, 1'b1);
      else
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
      if (pix_hs) idx++;
      if (hs_rgb) begin
        if (first_cyc < 0) first_cyc = budget;
        last_cyc = budget;
        n_bytes++;
      end
      if (fifo_level_a == 3'd4) begin
        saw_full = 1'b1;
        checkOutput("t2_ready_full", 32'(pix_ready_a), 32'd0);
      end else begin
        checkOutput("t2_ready_free", 32'(pix_ready_a), 32'd1);
      end
      budget++;
    end
    checkOutput("t2_bytes", 32'(n_bytes), 32'd24);
    checkOutput("t2_no_bubble", 32'(last_cyc - first_cyc + 1), 32'd24);
    checkOutput("t2_saw_full", 32'(saw_full), 32'd1);
    drain();

    $display("[TB] fifty pixels with random byte_ready");
    for (int p = 0; p < 50; p++) begin
      for (int gap = $urandom_range(0, 2); gap > 0; gap--)
        applyStimulus(1'b0, 8'hXX, 8'hXX, 8'hXX, 1'bX, 1'($urandom_range(0, 1)));
      sendPixel(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1);
    end
    drain();

    $display("[TB] reset in the middle of a pixel");
    applyStimulus(1'b1, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h04, 8'h05, 8'h06, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h07, 8'h08, 8'h09, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h0A, 8'h0B, 8'h0C, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    checkOutput("t5_queued", 32'(fifo_level_a), 32'd3);
    checkOutput("t5_in_b1", 32'({byte_valid_a, byte_first_a, byte_data_a}), 32'({1'b1, 1'b0, 8'h02}));
    reset = 1'b1;
    #1;
    checkOutput("t5_valid_cleared", 32'(byte_valid_a), 32'd0);
    checkOutput("t5_level_cleared", 32'(fifo_level_a), 32'd0);
    checkOutput("t5_data_cleared",  32'(byte_data_a),  32'd0);
    checkOutput("t5_ready_low",     32'(pix_ready_a),  32'd0);
    q_rgb.delete();
    q_bgr.delete();
    cnt_rgb = 16'd0;
    cnt_bgr = 16'd0;
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h5A, 8'h6B, 8'h7C, 1'b1, 1'b1);
    checkOutput("t5_accept", 32'(pix_hs), 32'd1);
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    checkOutput("t5_restart_b0", 32'({byte_valid_a, byte_first_a, byte_data_a}), 32'({1'b1, 1'b1, 8'h5A}));
    drain();
    checkOutput("t5_count", 32'(pixel_count_a), 32'd1);

    $display("[TB] pixel counter wrap");
    force u_dut_rgb.pixel_count_q = 16'hFFFF;
    force u_dut_bgr.pixel_count_q = 16'hFFFF;
    #1;
    release u_dut_rgb.pixel_count_q;
    release u_dut_bgr.pixel_count_q;
    cnt_rgb = 16'hFFFF;
    cnt_bgr = 16'hFFFF;
    @(negedge clk);
    checkOutput("t6_preset", 32'(pixel_count_a), 32'hFFFF);
    sendPixel(8'hDE, 8'hAD, 8'hBE, 1'b0, 1'b0);
    drain();
    checkOutput("t6_wrap", 32'(pixel_count_a), 32'd0);
    checkOutput("t6_wrap_b", 32'(pixel_count_b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
